error_uart_tx: RTL and testbench

Serializes the byte stream produced by the memory-test error reporter onto the board UART `tx` line, 8N1 by default, LSB first. It consumes `tx_data`/`tx_data_ready` from the reporter, returns `tx_data_accepted` as the per-byte handshake, and drives the top-level `tx` pin. One byte is in flight at a time. Back-to-back bytes are sent with zero idle gap.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_counter.sv | 29 ++
 rtl/error_uart_tx.sv | 137 +++++++++++++
 tb/tb_error_uart_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the error-reporter UART transmitter.
// Frame length helper used when sizing timing expectations.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int uart_frame_bits(int parity, int stop_bits);
    return 9 + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: flags the last cycle of each UART bit.
// Wraps on its own at bit end, so back-to-back bits need no clear.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_done = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || bit_done) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/error_uart_tx.sv
// 8-bit UART transmitter for the memory-test error reporter.
// Optional parity, 1 or 2 stop bits, zero-gap back-to-back frames.
module error_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_data_ready,
  input  logic [7:0] tx_data,
  output logic       tx_data_accepted,
  output logic       tx,
  output logic       busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN &&
      PARITY != PARITY_ODD) begin : g_bad_par
    $error("PARITY must be 0, 1 or 2");
  end

  uart_tx_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       par_q, par_d;
  logic       stop_q, stop_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       bit_done;
  logic       last_stop;
  logic       can_accept;
  logic       clear;

  assign clear = (state_q == ST_IDLE) || (state_d != state_q);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .bit_done(bit_done)
  );

  assign last_stop  = bit_done && (stop_q == 1'(STOP_BITS - 1));
  assign can_accept = (state_q == ST_IDLE) ||
                      ((state_q == ST_STOP) && last_stop);
  assign tx_data_accepted = can_accept & tx_data_ready & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    stop_d  = stop_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          stop_d  = 1'b0;
          if (idx_q == 3'd7)
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          stop_d = 1'b1;
          if (last_stop) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Acceptance overrides the STOP exit so frames chain with no gap.
    if (tx_data_accepted) begin
      state_d = ST_START;
      shift_d = tx_data;
      par_d   = (^tx_data) ^ (PARITY == PARITY_ODD);
    end
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_error_uart_tx.sv
// Four UART configurations checked cycle by cycle against
// an expected line-bit schedule built from the frame format.
module tb_error_uart_tx;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_c = 1'b0;
  logic       rdy [4];
  logic [7:0] dat [4];
  logic       acc [4];
  logic       txo [4];
  logic       bsy [4];

  int par_m [4] = '{0, 1, 2, 0};
  int stp_m [4] = '{1, 1, 1, 2};

  logic ring [4][64];
  int   rh [4];
  int   rl [4];
  logic [7:0] pend [4][8];
  int   pn [4];
  int   last_acc [4];
  int   prev_acc [4];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   noise = 1'b0;
  int   rel;

  always #5 clk = ~clk;

  error_uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(1), .PARITY(0)) u0 (
    .clk(clk), .rst(rst), .tx_data_ready(rdy[0]), .tx_data(dat[0]),
    .tx_data_accepted(acc[0]), .tx(txo[0]), .busy(bsy[0]));
  error_uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(1), .PARITY(1)) u1 (
    .clk(clk), .rst(rst), .tx_data_ready(rdy[1]), .tx_data(dat[1]),
    .tx_data_accepted(acc[1]), .tx(txo[1]), .busy(bsy[1]));
  error_uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(1), .PARITY(2)) u2 (
    .clk(clk), .rst(rst), .tx_data_ready(rdy[2]), .tx_data(dat[2]),
    .tx_data_accepted(acc[2]), .tx(txo[2]), .busy(bsy[2]));
  error_uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(2), .PARITY(0)) u3 (
    .clk(clk), .rst(rst), .tx_data_ready(rdy[3]), .tx_data(dat[3]),
    .tx_data_accepted(acc[3]), .tx(txo[3]), .busy(bsy[3]));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(int i, logic b);
    ring[i][(rh[i] + rl[i]) % 64] = b;
    rl[i]++;
  endtask

  task automatic push_frame(int i, logic [7:0] d);
    logic p;
    for (int k = 0; k < N; k++) push(i, 1'b0);
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < N; k++) push(i, d[b]);
    if (par_m[i] != 0) begin
      p = 1'b0;
      for (int b = 0; b < 8; b++) p = p ^ d[b];
      if (par_m[i] == 2) p = ~p;
      for (int k = 0; k < N; k++) push(i, p);
    end
    for (int k = 0; k < stp_m[i] * N; k++) push(i, 1'b1);
  endtask

  task automatic give(int i, logic [7:0] d);
    pend[i][pn[i]] = d;
    pn[i]++;
  endtask

  task automatic tick();
    logic ea [4];
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!rst) rl[i] = 0;
      ea[i] = rst && rdy[i] && (rl[i] <= 1);
      chk($sformatf("tx%0d", i), 32'(txo[i]),
          32'((rl[i] > 0) ? ring[i][rh[i]] : 1'b1));
      chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(rl[i] > 0));
      chk($sformatf("acc%0d", i), 32'(acc[i]), 32'(ea[i]));
      if (acc[i]) begin
        prev_acc[i] = last_acc[i];
        last_acc[i] = cyc;
      end
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        if (rl[i] > 0) begin
          rh[i] = (rh[i] + 1) % 64;
          rl[i]--;
        end
        if (ea[i]) begin
          push_frame(i, dat[i]);
          if (pn[i] > 0) begin
            for (int k = 0; k < 7; k++) pend[i][k] = pend[i][k+1];
            pn[i]--;
          end
        end
      end
    end
    cyc++;
    #1;
    rst = rst_c;
    for (int i = 0; i < 4; i++) begin
      if (noise && pn[i] == 0 && $urandom_range(2) == 0)
        give(i, 8'($urandom));
      if (noise && rl[i] > 1) begin
        rdy[i] = 1'($urandom_range(1));
        dat[i] = 8'($urandom);
      end else if (pn[i] > 0) begin
        rdy[i] = 1'b1;
        dat[i] = pend[i][0];
      end else begin
        rdy[i] = 1'b0;
        if (noise) dat[i] = 8'($urandom);
      end
    end
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rdy[i] = 1'b0;
      dat[i] = 8'h00;
      rh[i] = 0;
      rl[i] = 0;
      pn[i] = 0;
      last_acc[i] = -1;
      prev_acc[i] = -1;
    end
    give(0, 8'h55);
    give(1, 8'h07);
    give(2, 8'h07);
    give(3, 8'hFF);
    run(3);
    rst_c = 1'b1;
    tick();
    rel = cyc;
    tick();
    for (int i = 0; i < 4; i++)
      chk($sformatf("first_acc%0d", i), 32'(last_acc[i]), 32'(rel));
    run(60);

    give(0, 8'hA5); give(0, 8'h3C);
    give(1, 8'h07); give(1, 8'h07);
    give(2, 8'h07);
    give(3, 8'hFF); give(3, 8'hFF);
    run(100);
    chk("b2b_gap0", 32'(last_acc[0] - prev_acc[0]), 32'd40);
    chk("b2b_gap1", 32'(last_acc[1] - prev_acc[1]), 32'd44);
    chk("b2b_gap3", 32'(last_acc[3] - prev_acc[3]), 32'd44);

    for (int i = 0; i < 4; i++) give(i, 8'h0F);
    tick();
    tick();
    for (int i = 0; i < 4; i++) give(i, 8'h81);
    run(16);
    rst_c = 1'b0;
    run(3);
    rst_c = 1'b1;
    tick();
    rel = cyc;
    tick();
    for (int i = 0; i < 4; i++)
      chk($sformatf("post_rst_acc%0d", i), 32'(last_acc[i]), 32'(rel));
    run(60);

    noise = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(599) == 0) begin
        rst_c = 1'b0;
        tick();
        rst_c = 1'b1;
      end
      tick();
    end
    noise = 1'b0;
    run(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
